shift_sequencer: RTL and testbench

Multi-cycle shift/rotate engine for the 8-bit ALU. It accepts an operand, a shift amount, a direction and a mode, then applies one single-bit shift step per clock. The last bit shifted out is reported as a carry. It drives the single-step shift datapath: it generates `shift_in` each step, consumes `shift_out`, and returns the result over a valid/ready handshake.

---
 rtl/shift_sequencer_pkg.sv | 41 ++++
 rtl/shift_sequencer_if.sv | 31 +++
 rtl/shift_sequencer_shifter.sv | 26 ++
 rtl/shift_sequencer.sv | 97 +++++++++
 tb/tb_shift_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_sequencer_pkg.sv
// alu_shift_pkg: shared types and the per-step shift_in decode for the
// multi-cycle shift/rotate engine.
// Contents: shift_mode_t, shift_state_t, shift_in_sel().
// Config macro: SHIFT_SEQUENCER_ROTATE_EN. When it is undefined, rotate
// feedback is not compiled and mode 10 behaves as a logical shift.
package alu_shift_pkg;

    typedef enum logic [1:0] {
        LOGICAL = 2'b00,
        ARITH   = 2'b01,
        ROTATE  = 2'b10
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_t;

    // Bit entering the vacated end on one step.
    // msb       : current MSB of the working register
    // shift_out : bit leaving the register on this same step
    function automatic logic shift_in_sel(input logic [1:0] mode,
                                          input logic       is_left,
                                          input logic       msb,
                                          input logic       shift_out);
        logic bit_in;
        bit_in = 1'b0;
        case (mode)
            ARITH:   bit_in = is_left ? 1'b0 : msb;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
            ROTATE:  bit_in = shift_out;
`else
            ROTATE:  bit_in = 1'b0;
`endif
            default: bit_in = 1'b0;
        endcase
        return bit_in;
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/result handshake bundle for shift_sequencer.
// Request side : start_valid/start_ready, operand, amount, is_left_shift, mode
// Result side  : result, carry_out, done_valid/done_ready
// Status       : busy
// master = requester/consumer, slave = the engine.
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] operand;
    logic [AMT_W-1:0] amount;
    logic             is_left_shift;
    logic [1:0]       mode;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             done_valid;
    logic             done_ready;
    logic             busy;

    modport master (
        output start_valid, operand, amount, is_left_shift, mode, done_ready,
        input  start_ready, result, carry_out, done_valid, busy
    );

    modport slave (
        input  start_valid, operand, amount, is_left_shift, mode, done_ready,
        output start_ready, result, carry_out, done_valid, busy
    );
endinterface

// File: rtl/shift_sequencer_shifter.sv
// shifter: single-step, purely combinational one-bit shifter.
// Ports:
//   data_in   in  SIZE : value before the step
//   is_left   in  1    : 1 = shift toward MSB, 0 = toward LSB
//   shift_in  in  1    : bit entering the vacated end
//   data_out  out SIZE : value after the step
//   shift_out out 1    : bit leaving the register
module shifter #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] data_in,
    input  logic            is_left,
    input  logic            shift_in,
    output logic [SIZE-1:0] data_out,
    output logic            shift_out
);
    always_comb begin
        if (is_left) begin
            data_out  = {data_in[SIZE-2:0], shift_in};
            shift_out = data_in[SIZE-1];
        end else begin
            data_out  = {shift_in, data_in[SIZE-1:1]};
            shift_out = data_in[0];
        end
    end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift/rotate engine, one bit per clock.
// Ports:
//   clk   in : clock, rising edge
//   rst_n in : synchronous active-low reset
//   bus   slave modport of shift_sequencer_if (request, result, busy)
// Config macro: SHIFT_SEQUENCER_ROTATE_EN enables rotate for mode 10;
// without it mode 10 is a logical shift.
//
// state | meaning
// IDLE  | start_ready high, waiting for a request
// SHIFT | one single-bit step per cycle, counter counts down to 0
// DONE  | done_valid high, result/carry held until done_ready
module shift_sequencer
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_sequencer_if.slave   bus
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;
    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] cnt;
    logic             is_left_q;
    logic [1:0]       mode_q;
    logic             carry_q;

    logic [AMT_W-1:0] amt_eff;
    logic [WIDTH-1:0] step_data;
    logic             step_in;
    logic             step_out;

    assign amt_eff = (bus.amount > AMT_MAX) ? AMT_MAX : bus.amount;

    // step_out depends only on work, so feeding it back through the decode
    // for rotate does not form a combinational loop.
    assign step_in = shift_in_sel(mode_q, is_left_q, work[WIDTH-1], step_out);

    shifter #(.SIZE(WIDTH)) u_shifter (
        .data_in   (work),
        .is_left   (is_left_q),
        .shift_in  (step_in),
        .data_out  (step_data),
        .shift_out (step_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            work      <= '0;
            cnt       <= '0;
            is_left_q <= 1'b0;
            mode_q    <= 2'b00;
            carry_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_valid) begin
                        work      <= bus.operand;
                        cnt       <= amt_eff;
                        is_left_q <= bus.is_left_shift;
                        mode_q    <= bus.mode;
                        carry_q   <= 1'b0;
                        state     <= (amt_eff != '0) ? ST_SHIFT : ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    work    <= step_data;
                    carry_q <= step_out;
                    cnt     <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.done_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.start_ready = (state == ST_IDLE);
    assign bus.done_valid  = (state == ST_DONE);
    assign bus.busy        = (state == ST_SHIFT);
    assign bus.result      = work;
    assign bus.carry_out   = carry_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (WIDTH=8, AMT_W=4).
// Expected rotate results depend on SHIFT_SEQUENCER_ROTATE_EN.
module tb_shift_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    shift_sequencer_if #(.WIDTH(8), .AMT_W(4)) bus ();

    shift_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake one request, release done after it appears.
    // lat = first cycle after E0 with done_valid (0 on timeout).
    task automatic run_op(input logic [7:0] op, input logic [3:0] amt,
                          input logic left, input logic [1:0] md,
                          output logic [7:0] res, output logic cy,
                          output int lat, output int bcnt);
        @(negedge clk);
        bus.start_valid   = 1'b1;
        bus.operand       = op;
        bus.amount        = amt;
        bus.is_left_shift = left;
        bus.mode          = md;
        bus.done_ready    = 1'b0;
        @(posedge clk);
        #1 bus.start_valid = 1'b0;
        lat  = 0;
        bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done_valid) begin
                lat = k;
                break;
            end
        end
        res = bus.result;
        cy  = bus.carry_out;
        if (lat != 0) begin
            bus.done_ready = 1'b1;
            @(posedge clk);
            #1 bus.done_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.start_ready !== 1'b1) begin n_bad++; $display("FAIL reset_start_ready got %b want 1", bus.start_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done_valid !== 1'b0) begin n_bad++; $display("FAIL reset_done_valid got %b want 0", bus.done_valid); end
        n_cmp++; if (bus.result !== 8'h00) begin n_bad++; $display("FAIL reset_result got %h want 00", bus.result); end
        n_cmp++; if (bus.carry_out !== 1'b0) begin n_bad++; $display("FAIL reset_carry got %b want 0", bus.carry_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_logical_left();
        logic [7:0] r; logic c; int lat; int b;
        run_op(8'h81, 4'd1, 1'b1, 2'b00, r, c, lat, b);
        n_cmp++; if (r !== 8'h02) begin n_bad++; $display("FAIL ll_result got %h want 02", r); end
        n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL ll_carry got %b want 1", c); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ll_latency got %0d want 2", lat); end
        n_cmp++; if (b !== 1) begin n_bad++; $display("FAIL ll_busy got %0d want 1", b); end
    endtask

    task automatic test_arith_right();
        logic [7:0] r; logic c; int lat; int b;
        run_op(8'h90, 4'd3, 1'b0, 2'b01, r, c, lat, b);
        n_cmp++; if (r !== 8'hF2) begin n_bad++; $display("FAIL ar_result got %h want f2", r); end
        n_cmp++; if (c !== 1'b0) begin n_bad++; $display("FAIL ar_carry got %b want 0", c); end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ar_latency got %0d want 4", lat); end
        n_cmp++; if (b !== 3) begin n_bad++; $display("FAIL ar_busy got %0d want 3", b); end
        run_op(8'h90, 4'd3, 1'b0, 2'b00, r, c, lat, b);
        n_cmp++; if (r !== 8'h12) begin n_bad++; $display("FAIL lr_result got %h want 12", r); end
        n_cmp++; if (c !== 1'b0) begin n_bad++; $display("FAIL lr_carry got %b want 0", c); end
        run_op(8'h80, 4'd15, 1'b0, 2'b01, r, c, lat, b);
        n_cmp++; if (r !== 8'hFF) begin n_bad++; $display("FAIL ar_clamp_result got %h want ff", r); end
        n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL ar_clamp_carry got %b want 1", c); end
        run_op(8'h81, 4'd1, 1'b0, 2'b11, r, c, lat, b);
        n_cmp++; if (r !== 8'h40) begin n_bad++; $display("FAIL reserved_result got %h want 40", r); end
        n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL reserved_carry got %b want 1", c); end
    endtask

    task automatic test_rotate();
        logic [7:0] r; logic c; int lat; int b;
        logic [7:0] exp_r1;
        logic [7:0] exp_r2;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
        exp_r1 = 8'h80;
        exp_r2 = 8'hA5;
`else
        exp_r1 = 8'h00;
        exp_r2 = 8'h00;
`endif
        run_op(8'h01, 4'd1, 1'b0, 2'b10, r, c, lat, b);
        n_cmp++; if (r !== exp_r1) begin n_bad++; $display("FAIL rot_r_result got %h want %h", r, exp_r1); end
        n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL rot_r_carry got %b want 1", c); end
        run_op(8'hA5, 4'd12, 1'b1, 2'b10, r, c, lat, b);
        n_cmp++; if (r !== exp_r2) begin n_bad++; $display("FAIL rot_l_clamp_result got %h want %h", r, exp_r2); end
        n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL rot_l_clamp_carry got %b want 1", c); end
    endtask

    task automatic test_amount_bounds();
        logic [7:0] r; logic c; int lat; int b;
        run_op(8'h5A, 4'd0, 1'b1, 2'b00, r, c, lat, b);
        n_cmp++; if (r !== 8'h5A) begin n_bad++; $display("FAIL zero_result got %h want 5a", r); end
        n_cmp++; if (c !== 1'b0) begin n_bad++; $display("FAIL zero_carry got %b want 0", c); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL zero_latency got %0d want 1", lat); end
        n_cmp++; if (b !== 0) begin n_bad++; $display("FAIL zero_busy got %0d want 0", b); end
        run_op(8'hFF, 4'd12, 1'b1, 2'b00, r, c, lat, b);
        n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL clamp_result got %h want 00", r); end
        n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL clamp_carry got %b want 1", c); end
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL clamp_latency got %0d want 9", lat); end
        n_cmp++; if (b !== 8) begin n_bad++; $display("FAIL clamp_busy got %0d want 8", b); end
    endtask

    task automatic test_backpressure();
        int lat;
        int stray;
        @(negedge clk);
        bus.start_valid = 1'b1; bus.operand = 8'h81; bus.amount = 4'd1;
        bus.is_left_shift = 1'b1; bus.mode = 2'b00; bus.done_ready = 1'b0;
        @(posedge clk);
        #1 bus.start_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.done_valid) begin lat = k; break; end
        end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL bp_latency got %0d want 2", lat); end
        for (int i = 0; i < 5; i++) begin
            bus.start_valid = ~bus.start_valid;
            bus.operand = 8'h33 + 8'(i); bus.amount = 4'd2;
            @(negedge clk);
            n_cmp++; if (bus.result !== 8'h02) begin n_bad++; $display("FAIL bp_result got %h want 02", bus.result); end
            n_cmp++; if (bus.carry_out !== 1'b1) begin n_bad++; $display("FAIL bp_carry got %b want 1", bus.carry_out); end
            n_cmp++; if (bus.start_ready !== 1'b0) begin n_bad++; $display("FAIL bp_start_ready got %b want 0", bus.start_ready); end
            n_cmp++; if (bus.done_valid !== 1'b1) begin n_bad++; $display("FAIL bp_done_valid got %b want 1", bus.done_valid); end
        end
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b1;
        @(posedge clk);
        #1 bus.done_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.start_ready !== 1'b1) begin n_bad++; $display("FAIL bp_idle got %b want 1", bus.start_ready); end
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || bus.done_valid) stray++;
        end
        n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL bp_not_queued got %0d want 0", stray); end
    endtask

    task automatic test_back_to_back();
        int hs[3];
        int n_hs;
        int n_done;
        int bad_res;
        @(negedge clk);
        bus.start_valid = 1'b1; bus.operand = 8'h0F; bus.amount = 4'd2;
        bus.is_left_shift = 1'b1; bus.mode = 2'b00; bus.done_ready = 1'b1;
        n_hs = 0; n_done = 0; bad_res = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done_valid) begin
                n_done++;
                if (bus.result !== 8'h3C) bad_res++;
            end
            if (bus.start_ready) begin
                hs[n_hs] = k;
                n_hs++;
                if (n_hs == 3) break;
            end
            @(negedge clk);
        end
        bus.start_valid = 1'b0;
        n_cmp++; if (n_hs !== 3) begin n_bad++; $display("FAIL b2b_handshakes got %0d want 3", n_hs); end
        n_cmp++; if ((hs[1] - hs[0]) !== 4 || (hs[2] - hs[1]) !== 4) begin n_bad++; $display("FAIL b2b_period got %0d,%0d want 4,4", hs[1] - hs[0], hs[2] - hs[1]); end
        n_cmp++; if (n_done !== 2) begin n_bad++; $display("FAIL b2b_done_cycles got %0d want 2", n_done); end
        n_cmp++; if (bad_res !== 0) begin n_bad++; $display("FAIL b2b_result bad %0d want 0", bad_res); end
        @(negedge clk);
        bus.done_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int stray;
        @(negedge clk);
        bus.start_valid = 1'b1; bus.operand = 8'hFF; bus.amount = 4'd6;
        bus.is_left_shift = 1'b1; bus.mode = 2'b00; bus.done_ready = 1'b1;
        @(posedge clk);
        #1 bus.start_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got %b want 1", bus.busy); end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.start_ready !== 1'b1) begin n_bad++; $display("FAIL mid_start_ready got %b want 1", bus.start_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.result !== 8'h00) begin n_bad++; $display("FAIL mid_result got %h want 00", bus.result); end
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done_valid) stray++;
        end
        n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL mid_no_done got %0d want 0", stray); end
        bus.done_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.start_valid   = 1'b0;
        bus.operand       = '0;
        bus.amount        = '0;
        bus.is_left_shift = 1'b0;
        bus.mode          = 2'b00;
        bus.done_ready    = 1'b0;
        test_reset();
        test_logical_left();
        test_arith_right();
        test_rotate();
        test_amount_bounds();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
